// File: rtl/oled_spi_tx_if.sv
// oled_spi_tx_if: byte handshake between a host and the OLED SPI transmitter.
interface oled_spi_tx_if;
    logic [7:0] tx_data;
    logic       tx_dc;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    modport master (output tx_data, tx_dc, tx_valid, input tx_ready, busy);
    modport slave  (input tx_data, tx_dc, tx_valid, output tx_ready, busy);
endinterface

// File: rtl/oled_spi_tx.sv
// oled_spi_tx: SPI mode-0 byte transmitter for an OLED display with D/C select
// and chip-select held low across back-to-back bytes.
module oled_spi_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    oled_spi_tx_if.slave      bus,
    output logic              OLED_SS,
    output logic              OLED_DC,
    output logic              SCK,
    output logic              MOSI
);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT_HI, DONE} state_t;
    localparam logic [7:0] HALF = 8'(CLK_DIV - 1);
    state_t     r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_shift;
    logic [3:0] r_bit;
    logic       r_ready;
    logic       r_ss;
    logic       r_dc;
    logic       r_sck;
    logic       r_mosi;
    logic       w_hs;
    assign w_hs        = bus.tx_valid & r_ready;
    assign bus.tx_ready = r_ready;
    assign bus.busy     = ~r_ss;
    assign OLED_SS      = r_ss;
    assign OLED_DC      = r_dc;
    assign SCK          = r_sck;
    assign MOSI         = r_mosi;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_bit   <= '0;
            r_ready <= 1'b0;
            r_ss    <= 1'b1;
            r_dc    <= 1'b0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_cnt <= HALF;
                    if (w_hs) begin
                        r_state <= SETUP;
                        r_shift <= bus.tx_data;
                        r_mosi  <= bus.tx_data[7];
                        r_dc    <= bus.tx_dc;
                        r_bit   <= '0;
                        r_ready <= 1'b0;
                        r_ss    <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_ss    <= 1'b1;
                    end
                end
                SETUP: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= SHIFT_HI;
                        r_sck   <= 1'b1;
                        r_cnt   <= HALF;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                SHIFT_HI: begin
                    // MOSI only moves together with the falling SCK edge
                    if (r_cnt == 8'd0) begin
                        r_sck <= 1'b0;
                        r_bit <= r_bit + 4'd1;
                        r_cnt <= HALF;
                        if (r_bit == 4'd7) begin
                            r_state <= DONE;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= SETUP;
                            r_shift <= {r_shift[6:0], 1'b0};
                            r_mosi  <= r_shift[6];
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
